// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the fetch PC unit.
// No logic; imported by pc_unit and ras_stack.
// Default vectors are 32-bit; modules cast them to their own XLEN.
package pc_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;
    localparam int          PC_INC               = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_RET,
        SEL_TRAP
    } next_pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop/replace, saturating count.
// Latency: writes and pointer moves land on the next rising edge.
// Backpressure: none; enable=0 holds all state and suppresses underflow.
module ras_stack
    import pc_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    output logic            underflow
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   tp_q, tp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            uflow_q, uflow_d;
    logic [PW-1:0]   wr_idx;
    logic            wr_en;

    assign top       = mem_q[tp_q];
    assign count     = cnt_q;
    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign underflow = uflow_q;

    // Pointer/count update; push+pop together only reaches here when empty,
    // in which case the push wins and the pop is reported as underflow.
    always_comb begin
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        uflow_d = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = tp_q;
        if (enable) begin
            if (replace) begin
                wr_en  = 1'b1;
                wr_idx = tp_q;
            end else if (push) begin
                wr_en  = 1'b1;
                wr_idx = tp_q + 1'b1;
                tp_d   = tp_q + 1'b1;
                if (!full) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (pop && !empty) begin
                tp_d  = tp_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
            uflow_d = pop & empty;
        end
    end

    // Pointer, count and underflow pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q    <= '0;
            cnt_q   <= '0;
            uflow_q <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            cnt_q   <= cnt_d;
            uflow_q <= uflow_d;
        end
    end

    // Entry storage is deliberately not cleared by reset; count gates validity.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised ret/jump/branch redirect and a RAS.
// Latency: one cycle from sampled controls to pc_out; no bubbles.
// Backpressure: enable=0 stalls PC and RAS; optional PC_MISALIGN_TRAP_EN traps misaligned targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       branch_taken,
    input  logic [XLEN-1:0]            branch_target,
    input  logic                       jump,
    input  logic [XLEN-1:0]            jump_target,
    input  logic                       call,
    input  logic                       ret,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc_plus4,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_underflow,
    output logic                       misalign
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] redir_tgt;
    logic            ret_hit;
    logic            trap_hit;
    next_pc_sel_e    sel_raw, sel;

    assign pc_out   = pc_q;
    assign pc_plus4 = pc_q + XLEN'(PC_INC);
    assign misalign = misalign_q;

    // A ret that finds a valid entry; call+ret on such an entry rewrites the top in place.
    assign ret_hit = ret & ~ras_empty;

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .push      (call & ~ret_hit),
        .pop       (ret & ~(call & ret_hit)),
        .replace   (call & ret_hit),
        .wdata     (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .underflow (ras_underflow)
    );

    // Redirect priority: ret over jump over branch; ret on an empty RAS falls through to sequential.
    always_comb begin
        sel_raw = SEL_SEQ;
        if (ret) begin
            if (!ras_empty) begin
                sel_raw = SEL_RET;
            end
        end else if (jump) begin
            sel_raw = SEL_JUMP;
        end else if (branch_taken) begin
            sel_raw = SEL_BRANCH;
        end
    end

    // Candidate redirect target plus the optional alignment trap on it.
    always_comb begin
        case (sel_raw)
            SEL_RET:    redir_tgt = ras_top;
            SEL_JUMP:   redir_tgt = jump_target;
            SEL_BRANCH: redir_tgt = branch_target;
            default:    redir_tgt = pc_plus4;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        trap_hit = (sel_raw != SEL_SEQ) && (redir_tgt[1:0] != 2'b00);
`else
        trap_hit = 1'b0;
`endif
        sel = trap_hit ? SEL_TRAP : sel_raw;
    end

    // Final next-PC mux.
    always_comb begin
        case (sel)
            SEL_TRAP: pc_d = TRAP_VECTOR;
            SEL_SEQ:  pc_d = pc_plus4;
            default:  pc_d = redir_tgt;
        endcase
    end

    // PC and misalign pulse registers; reset beats everything, stall holds PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else if (enable) begin
            pc_q       <= pc_d;
            misalign_q <= trap_hit;
        end else begin
            misalign_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table plus randomized run against a queue-based model.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at the same point.
// Honours PC_MISALIGN_TRAP_EN in its expectations.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0080;
    localparam int          DEPTH = 4;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, branch_taken, jump, call, ret;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, pc_plus4;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_underflow, misalign;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic en, input logic b, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic c, input logic r);
        reset = rs; enable = en; branch_taken = b; branch_target = bt;
        jump = jp; jump_target = jt; call = c; ret = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf, m_mis;

    task automatic model_step(input logic rs, input logic en, input logic b, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic c, input logic r);
        logic [31:0] p4, nxt;
        bit redir;
        if (rs) begin
            m_pc = RV; m_ras.delete(); m_uf = 1'b0; m_mis = 1'b0;
        end else if (!en) begin
            m_uf = 1'b0; m_mis = 1'b0;
        end else begin
            p4 = m_pc + 32'd4;
            m_uf = r && (m_ras.size() == 0);
            m_mis = 1'b0;
            redir = 1'b0;
            nxt = p4;
            if (r) begin
                if (m_ras.size() > 0) begin nxt = m_ras[m_ras.size()-1]; redir = 1'b1; end
            end else if (jp) begin
                nxt = jt; redir = 1'b1;
            end else if (b) begin
                nxt = bt; redir = 1'b1;
            end
            if (c && r && m_ras.size() > 0) begin
                m_ras[m_ras.size()-1] = p4;
            end else if (c) begin
                m_ras.push_back(p4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (r && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
            if (TRAP_ON && redir && (nxt[1:0] != 2'b00)) begin
                nxt = TV; m_mis = 1'b1;
            end
            m_pc = nxt;
        end
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d pc_out", cyc), pc_out, m_pc);
        chk($sformatf("rnd%0d pc_plus4", cyc), pc_plus4, m_pc + 32'd4);
        chk($sformatf("rnd%0d ras_count", cyc), {29'd0, ras_count}, m_ras.size());
        chk($sformatf("rnd%0d ras_empty", cyc), {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
        chk($sformatf("rnd%0d ras_full", cyc), {31'd0, ras_full}, {31'd0, m_ras.size() == DEPTH});
        chk($sformatf("rnd%0d ras_underflow", cyc), {31'd0, ras_underflow}, {31'd0, m_uf});
        chk($sformatf("rnd%0d misalign", cyc), {31'd0, misalign}, {31'd0, m_mis});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, en, br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        c, r;
        logic [31:0] pc;
        int          cnt;
        logic        uf, mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic c, input logic r,
                                input logic [31:0] pc, input int cnt, input logic uf, input logic mis);
        vec_t v;
        v.rst = rst; v.en = en; v.br = br; v.bt = bt; v.j = j; v.jt = jt; v.c = c; v.r = r;
        v.pc = pc; v.cnt = cnt; v.uf = uf; v.mis = mis;
        return v;
    endfunction

    initial begin
        logic [31:0] mis_pc;
        logic        rs, en, b, jp, c, r;
        logic [31:0] bt, jt;

        mis_pc = TRAP_ON ? TV : 32'h102;
        //                 rst en br bt          j  jt            c  r  pc             cnt uf mis
        tbl.push_back(mk(1, 0, 0, 0,          0, 0,            0, 0, 32'h0,         0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 0, 32'h4,         0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 0, 32'h8,         0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 0, 32'hC,         0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,          1, 32'h40,       0, 0, 32'h0,         0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h10,       0, 0, 32'h10,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,          1, 32'h80,       0, 0, 32'h10,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,          1, 32'h80,       1, 0, 32'h10,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h20,       0, 0, 32'h20,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h80,       1, 0, 32'h80,        1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'hC0,       1, 0, 32'hC0,        2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h84,        1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h24,        0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h100,    1, 32'h200,      0, 0, 32'h200,       0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h40,       0, 0, 32'h40,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h300,      1, 0, 32'h300,       1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h100,    1, 32'h200,      0, 1, 32'h44,        0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h48,        0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h1000,     1, 0, 32'h1000,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h2000,     1, 0, 32'h2000,      2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h3000,     1, 0, 32'h3000,      3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h4000,     1, 0, 32'h4000,      4, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h5000,     1, 0, 32'h5000,      4, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h4004,      3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h3004,      2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h2004,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h1004,      0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h1008,      0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 1, 32'h100C,      1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            1, 1, 32'h100C,      1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 1, 32'h1010,      0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'h102,      0, 0, mis_pc,        0, 0, TRAP_ON));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 0, mis_pc + 32'd4, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,          0, 0,            0, 0, 32'h0,         0, 0, 0));

        reset = 1'b1; enable = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt, tbl[i].c, tbl[i].r);
            chk($sformatf("row%0d pc_out", i), pc_out, tbl[i].pc);
            chk($sformatf("row%0d pc_plus4", i), pc_plus4, tbl[i].pc + 32'd4);
            chk($sformatf("row%0d ras_count", i), {29'd0, ras_count}, tbl[i].cnt);
            chk($sformatf("row%0d ras_full", i), {31'd0, ras_full}, {31'd0, tbl[i].cnt == DEPTH});
            chk($sformatf("row%0d ras_empty", i), {31'd0, ras_empty}, {31'd0, tbl[i].cnt == 0});
            chk($sformatf("row%0d ras_underflow", i), {31'd0, ras_underflow}, {31'd0, tbl[i].uf});
            chk($sformatf("row%0d misalign", i), {31'd0, misalign}, {31'd0, tbl[i].mis});
        end

        // Randomized run against the model, starting from a reset.
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check_model(-1);
        for (int k = 0; k < 600; k++) begin
            rs = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 99) < 85);
            b  = ($urandom_range(0, 3) == 0);
            jp = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                bt[1:0] = 2'b00;
                jt[1:0] = 2'b00;
            end
            model_step(rs, en, b, bt, jp, jt, c, r);
            drive(rs, en, b, bt, jp, jt, c, r);
            check_model(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-cycle CPU's program-counter register.
- Holds the fetch PC with synchronous reset to a configurable vector and an enable/stall hold.
- Adds sequential increment, prioritised branch/jump redirect, and a circular return-address stack (RAS) for call/return.
- Sits between the control unit / branch comparator and the instruction-memory address port.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, at least 2.
- TRAP_VECTOR, 32'h0000_0080, redirect address for a misaligned target (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = PC/RAS may update this cycle; 0 = stall, all state held
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  XLEN  branch destination
- jump  in  1  unconditional jump
- jump_target  in  XLEN  jump destination
- call  in  1  push pc_plus4 onto RAS; normally asserted together with jump
- ret  in  1  pop RAS top into PC
- pc_out  out  XLEN  current fetch PC, registered
- pc_plus4  out  XLEN  pc_out + 4, combinational, modulo 2^XLEN
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty  out  1  ras_count == 0
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_underflow  out  1  one-cycle pulse: ret taken with RAS empty
- misalign  out  1  one-cycle pulse: misaligned target (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - pc_out = RESET_VECTOR.
  - RAS pointer and ras_count = 0; RAS contents not cleared.
  - ras_underflow = 0, misalign = 0.
  - reset overrides enable and all other inputs in the same cycle.
- enable = 0: pc_out, RAS, pointer and count are held. Pulse outputs are 0 during a stall.
- enable = 1, next-PC priority:
  - ret: pc_out <= RAS top, or pc_plus4 if the RAS is empty.
  - else jump: pc_out <= jump_target.
  - else branch_taken: pc_out <= branch_target.
  - else: pc_out <= pc_plus4.
- Latency: redirect is visible on pc_out the cycle after the inputs are sampled. No bubble is inserted.
- RAS is circular, indexed by top pointer tp (mod RAS_DEPTH):
  - Push (call & !ret): entry[tp+1] <= pc_plus4; tp++.
    - ras_count increments, saturating at RAS_DEPTH.
    - When full, the oldest entry is silently overwritten.
  - Pop (ret & !call, count > 0): tp--; ras_count decrements.
  - ret with count 0: pointer and count unchanged; ras_underflow = 1 for one cycle.
  - call & ret together, count > 0: pc_out <= entry[tp]; entry[tp] <= pc_plus4; tp and count unchanged.
  - call & ret together, count 0: pc_out <= pc_plus4; push performed; ras_underflow = 1.
- Arithmetic: all PC math is unsigned modulo 2^XLEN. Example: XLEN=32, pc_out = 32'hFFFF_FFFC gives pc_plus4 = 0.
- All registered outputs update only on the rising edge; no asynchronous paths.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - If the selected redirect target (RAS top, jump_target or branch_target) has bits [1:0] != 0, pc_out <= TRAP_VECTOR and misalign pulses 1 for one cycle.
  - Any RAS push/pop in that cycle still occurs.
  - Sequential increments are never checked.
- Undefined: targets are loaded as-is and misalign is tied to 0.

Decomposition:
- Shared package pc_pkg holds:
  - the default constants RESET_VECTOR and TRAP_VECTOR;
  - localparam PC_INC = 4;
  - typedef enum next_pc_sel_e {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_RET, SEL_TRAP}.
- One natural sub-module: ras_stack. It holds the circular buffer, pointer and count, with push/pop/replace ports and full/empty/underflow outputs.
- pc_unit contains the next-PC mux and the PC register.

Test Plan:
- Reset then 3 enabled cycles, no controls -> pc_out 0, 4, 8, 12. Assert reset with jump=1, jump_target=0x40 -> pc_out = 0 next cycle.
- enable=0 for 2 cycles at pc 0x10 with jump=1 -> pc_out stays 0x10, ras_count unchanged. enable=1 -> pc_out = jump_target.
- Same cycle: branch_taken=1 target 0x100, jump=1 target 0x200 -> pc_out = 0x200. Add ret with top 0x44 -> pc_out = 0x44.
- From pc 0x20: call+jump to 0x80, then call+jump to 0xC0, then ret, ret -> pc sequence 0x80, 0xC0, 0x84, 0x24; ras_count 1, 2, 1, 0.
- RAS_DEPTH=4: 5 pushes, then 5 rets -> ras_full after push 4, count saturates at 4. First 4 pops return the newest 4 addresses. Fifth ret -> pc_plus4 and ras_underflow pulse.
- With PC_MISALIGN_TRAP_EN: jump_target 0x102 -> pc_out = 0x80, misalign pulses 1 cycle. Without the macro -> pc_out = 0x102, misalign = 0.
